// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Streams 32-bit instruction words from a valid/ready source
//                into a byte-wide instruction memory. Each word is written
//                big-endian, so word[31:24] goes to the lowest address. The
//                processor is held in reset for the whole session.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              rising-edge clock
//    rst_n            asynchronous active-low reset
//    i_start          one-cycle session request (honoured only when idle)
//    i_base_addr      byte address of the first word (captured with start)
//    i_word_count     number of words in the session (captured with start)
//    i_s_valid        source has a word available
//    i_s_data         source instruction word
//    o_s_ready        loader takes a word this cycle
//    o_mem_we         byte write strobe
//    o_mem_waddr      byte write address
//    o_mem_wdata      byte write data
//    o_busy           session in progress (start through done)
//    o_cpu_hold       processor reset hold, identical to o_busy
//    o_done           one-cycle end-of-session pulse
//    o_err            sticky error, cleared by the next accepted start
//    o_words_written  words fully written in the current / last session
// ============================================================================
module imem_loader #(
  parameter int BUS_WIDTH = 32,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [BUS_WIDTH-1:0] i_base_addr,
  input  logic [15:0]          i_word_count,
  input  logic                 i_s_valid,
  input  logic [BUS_WIDTH-1:0] i_s_data,
  output logic                 o_s_ready,
  output logic                 o_mem_we,
  output logic [BUS_WIDTH-1:0] o_mem_waddr,
  output logic [WIDTH-1:0]     o_mem_wdata,
  output logic                 o_busy,
  output logic                 o_cpu_hold,
  output logic                 o_done,
  output logic                 o_err,
  output logic [15:0]          o_words_written
);

  // Highest byte address at which a whole word still fits in memory.
  localparam logic [BUS_WIDTH-1:0] c_LAST_WORD_ADDR = BUS_WIDTH'(DEPTH - 4);
  localparam logic [BUS_WIDTH-1:0] c_WORD_BYTES     = BUS_WIDTH'(4);
  localparam logic [BUS_WIDTH-1:0] c_ONE            = BUS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;

  logic [BUS_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic [15:0]           r_count, w_count_nxt;
  logic [BUS_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [1:0]            r_k, w_k_nxt;
  logic [15:0]           r_words, w_words_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_s_ready, w_s_ready_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [BUS_WIDTH-1:0]  r_mem_waddr, w_mem_waddr_nxt;
  logic [WIDTH-1:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [15:0]           w_words_inc;
  logic                  w_misaligned;

  assign w_words_inc  = r_words + 16'd1;
  assign w_misaligned = (i_base_addr[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and next values of every registered output. Outputs are
  // computed one cycle ahead so that each one comes straight from a flop.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_count_nxt     = r_count;
    w_shift_nxt     = r_shift;
    w_k_nxt         = r_k;
    w_words_nxt     = r_words;
    w_err_nxt       = r_err;
    w_mem_we_nxt    = 1'b0;
    w_mem_waddr_nxt = r_mem_waddr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr_nxt  = i_base_addr;
          w_count_nxt = i_word_count;
          w_words_nxt = 16'd0;
          w_err_nxt   = w_misaligned;
          if (w_misaligned || (i_word_count == 16'd0)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        // o_s_ready is high throughout FETCH, so valid alone means accept.
        if (i_s_valid) begin
          if (r_addr > c_LAST_WORD_ADDR) begin
            // Word would run past the end of memory: drop it, flag, finish.
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_shift_nxt     = i_s_data;
            w_k_nxt         = 2'd0;
            w_mem_we_nxt    = 1'b1;
            w_mem_waddr_nxt = r_addr;
            w_mem_wdata_nxt = i_s_data[BUS_WIDTH-1 -: WIDTH];
            w_state_nxt     = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (r_k != 2'd3) begin
          // The byte on the bus is always the top of r_shift; the next one
          // sits just below it, and the shift lines it up for the cycle after.
          w_k_nxt         = r_k + 2'd1;
          w_mem_we_nxt    = 1'b1;
          w_mem_waddr_nxt = r_mem_waddr + c_ONE;
          w_mem_wdata_nxt = r_shift[BUS_WIDTH-1-WIDTH -: WIDTH];
          w_shift_nxt     = r_shift << WIDTH;
        end else begin
          w_words_nxt = w_words_inc;
          w_addr_nxt  = r_addr + c_WORD_BYTES;
          if (w_words_inc < r_count) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_s_ready_nxt = (w_state_nxt == S_FETCH);
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_shift     <= '0;
      r_k         <= '0;
      r_words     <= '0;
      r_err       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_count     <= w_count_nxt;
      r_shift     <= w_shift_nxt;
      r_k         <= w_k_nxt;
      r_words     <= w_words_nxt;
      r_err       <= w_err_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_waddr <= w_mem_waddr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_s_ready       = r_s_ready;
  assign o_mem_we        = r_mem_we;
  assign o_mem_waddr     = r_mem_waddr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_busy          = r_busy;
  assign o_cpu_hold      = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_words_written = r_words;

endmodule
`default_nettype wire
